multi_lane_fifo: RTL and testbench
==================================

Name: multi_lane_fifo

Overview:
Parametrised in-order FIFO with IN_W enqueue lanes and OUT_W dequeue lanes per cycle. It is the superscalar successor to the single-lane handshake FIFO, used between fetch/decode/dispatch stages where several instructions move per cycle. It adds lane compaction, prefix-ordered multi-pop, a synchronous flush for pipeline redirects, and an occupancy output.

Parameters:
DEPTH, 16, number of entries; must be >= IN_W and >= OUT_W; a power of two is not required.
IN_W, 4, enqueue lanes per cycle.
OUT_W, 4, dequeue lanes per cycle.
T, logic[31:0], entry payload type.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
flush_i  in  1  synchronous flush; discards all contents.
enq_valid_i  in  IN_W  per-lane enqueue valid; any mask is allowed.
enq_data_i  in  IN_W x T  per-lane enqueue payload.
enq_ready_o  out  1  registered; when 1, all valid lanes are accepted this cycle.
deq_valid_o  out  OUT_W  lane j is valid iff count_q > j.
deq_data_o  out  OUT_W x T  entry at rptr+j (mod DEPTH).
deq_ready_i  in  OUT_W  per-lane consumer ready.
count_o  out  CNT_W  registered occupancy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wptr, rptr and count_q are set to 0.
  - enq_ready_o is 0 during reset and rises to 1 on the first edge after rst_n=1.
  - deq_valid_o = 0 and count_o = 0.
  - Storage is not reset; deq_data_o is don't-care on invalid lanes.
- Enqueue:
  - Takes effect only when enq_ready_o=1.
  - n_enq = popcount(enq_valid_i).
  - Valid lanes are compacted in ascending lane order and written to wptr, wptr+1, ... (mod DEPTH).
  - Example: mask 4'b1010 writes lane1 to wptr and lane3 to wptr+1.
  - When enq_ready_o=0, enq_valid_i is ignored and nothing is written.
- Dequeue:
  - n_deq = number of leading lanes, starting at lane 0, with deq_valid_o[j] & deq_ready_i[j].
  - Counting stops at the first lane that fails; later lanes are not popped even if their ready is 1.
  - rptr advances by n_deq (mod DEPTH).
- Count and ready:
  - count_next = count_q + n_enq - n_deq.
  - enq_ready_next = (DEPTH - count_next) >= IN_W.
  - Both are registered, so enq_ready_o is conservative by one cycle.
- Latency: enqueue to visibility on deq_valid_o is 1 cycle. There is no combinational bypass.
- Wrap-around:
  - Pointers advance modulo DEPTH using add-then-conditional-subtract, which is legal for non-power-of-2 DEPTH.
  - Read lane addressing applies the same modulo rule.
- Simultaneous enqueue and dequeue:
  - Both occur in the same cycle and count_next uses both.
  - Storage is read from registered state, so freeing and refilling the same slot in one cycle is safe.
- Flush:
  - flush_i=1 at an edge sets wptr, rptr and count to 0 and enq_ready to 1.
  - Any enqueue or dequeue in that cycle is discarded; the consumer must treat the data as squashed.
  - If rst_n=0 coincides with flush_i, reset wins and enq_ready becomes 0.
- Full and empty:
  - count=DEPTH gives enq_ready_o=0.
  - count=0 gives deq_valid_o=0.
  - No overflow is possible because of the conservative ready.
  - Underflow is impossible by construction of n_deq.
- Invariant (checked by assertion): count_q <= DEPTH.

Decomposition:
- The shared package holds:
  - the default payload typedef;
  - a wrap-add helper function (ptr, inc, DEPTH);
  - a popcount function.
- One sub-module, lane_compact, is natural:
  - input: IN_W valid mask plus data;
  - output: compacted data vector and n_enq;
  - combinational, built as a prefix-sum over the mask.
- Everything else is flat in multi_lane_fifo.

Test Plan:
Use DEPTH=6, IN_W=2, OUT_W=2, with payload values visible.
- Reset: hold rst_n=0 for 3 cycles, then release -> enq_ready_o=0 until the first edge after release, then 1; count_o=0; deq_valid_o=2'b00.
- Compaction: enqueue mask 2'b10 with data {B,A}, then mask 2'b11 with {D,C} -> deq_data_o lane0=B, lane1=C next cycle; count_o=3.
- Prefix pop: with 3 entries and deq_ready_i=2'b10 -> nothing pops, count stays 3; then 2'b01 -> 1 pop, count_o=2.
- Full and wrap: fill to count 5 -> enq_ready_o=0 (free 1 < 2). Pop 2 while enqueueing 2 repeatedly for 10 cycles -> in-order data across pointer wrap at 6, count_o steady.
- Flush: count=4 with simultaneous enqueue/dequeue and flush_i=1 -> next cycle count_o=0, deq_valid_o=0, enq_ready_o=1, and the discarded data never appears.
- Reset mid-operation: count=4 and enqueue active, then rst_n=0 for 1 cycle -> count_o=0 and enq_ready_o=0, and after release the FIFO behaves as if freshly reset.

Source files
------------

// File: rtl/multi_lane_fifo_pkg.sv
// Shared types and helpers for the multi-lane FIFO: default payload type,
// modulo pointer increment and mask popcount.
package multi_lane_fifo_pkg;

    typedef logic [31:0] payload_t;

    // Valid only when ptr < depth and inc <= depth, which every caller guarantees.
    function automatic int unsigned wrap_add(
        input int unsigned ptr,
        input int unsigned inc,
        input int unsigned depth
    );
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_lane_fifo_lane_compact.sv
// Packs the valid enqueue lanes into consecutive slots in ascending lane order
// and reports how many lanes were valid.
module lane_compact
    import multi_lane_fifo_pkg::*;
#(
    parameter int  IN_W = 4,
    parameter type T    = payload_t
)(
    input  logic [IN_W-1:0]            valid_i,
    input  T     [IN_W-1:0]            data_i,
    output T     [IN_W-1:0]            data_o,
    output logic [$clog2(IN_W+1)-1:0]  n_o
);

    localparam int NW = $clog2(IN_W + 1);

    // pos[i] is the slot a valid lane i lands in: the count of valid lanes below it.
    logic [NW-1:0] pos [IN_W];

    for (genvar gi = 0; gi < IN_W; gi++) begin : g_prefix
        assign pos[gi] = NW'(popcount(32'(valid_i & IN_W'((1 << gi) - 1))));
    end

    assign n_o = NW'(popcount(32'(valid_i)));

    always_comb begin
        data_o = '0;
        for (int k = 0; k < IN_W; k++) begin
            for (int i = k; i < IN_W; i++) begin
                if (valid_i[i] && (pos[i] == NW'(k))) begin
                    data_o[k] = data_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/multi_lane_fifo.sv
// In-order FIFO moving up to IN_W entries in and OUT_W entries out per cycle,
// with synchronous flush and a registered, one-cycle-conservative enqueue ready.
module multi_lane_fifo
    import multi_lane_fifo_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  IN_W  = 4,
    parameter int  OUT_W = 4,
    parameter type T     = payload_t,
    parameter int  CNT_W = $clog2(DEPTH + 1)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [IN_W-1:0]     enq_valid_i,
    input  T     [IN_W-1:0]     enq_data_i,
    output logic                enq_ready_o,
    output logic [OUT_W-1:0]    deq_valid_o,
    output T     [OUT_W-1:0]    deq_data_o,
    input  logic [OUT_W-1:0]    deq_ready_i,
    output logic [CNT_W-1:0]    count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW    = $clog2(IN_W + 1);
    localparam int ND    = $clog2(OUT_W + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq_ready_q, enq_ready_d;

    T     [IN_W-1:0]  comp_data;
    logic [NW-1:0]    n_enq_raw;
    logic [NW-1:0]    n_enq;
    logic [ND-1:0]    n_deq;
    logic             deq_stop;

    lane_compact #(
        .IN_W (IN_W),
        .T    (T)
    ) u_compact (
        .valid_i (enq_valid_i),
        .data_i  (enq_data_i),
        .data_o  (comp_data),
        .n_o     (n_enq_raw)
    );

    assign n_enq = enq_ready_q ? n_enq_raw : '0;

    // Reads come straight from registered storage, so a slot freed this cycle can be refilled safely.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_read
        assign deq_valid_o[gi] = (count_q > CNT_W'(gi));
        assign deq_data_o[gi]  = mem_q[PTR_W'(wrap_add(32'(rptr_q), 32'(gi), 32'(DEPTH)))];
    end

    always_comb begin
        n_deq    = '0;
        deq_stop = 1'b0;
        for (int j = 0; j < OUT_W; j++) begin
            if (!deq_stop && deq_valid_o[j] && deq_ready_i[j]) begin
                n_deq = n_deq + ND'(1);
            end else begin
                deq_stop = 1'b1;
            end
        end
    end

    always_comb begin
        wptr_d  = PTR_W'(wrap_add(32'(wptr_q), 32'(n_enq), 32'(DEPTH)));
        rptr_d  = PTR_W'(wrap_add(32'(rptr_q), 32'(n_deq), 32'(DEPTH)));
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        enq_ready_d = ((int'(count_d) + IN_W) <= DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            enq_ready_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            enq_ready_q <= enq_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i) begin
            for (int k = 0; k < IN_W; k++) begin
                if (NW'(k) < n_enq) begin
                    mem_q[PTR_W'(wrap_add(32'(wptr_q), 32'(k), 32'(DEPTH)))] <= comp_data[k];
                end
            end
        end
    end

    assign enq_ready_o = enq_ready_q;
    assign count_o     = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed bench for multi_lane_fifo with DEPTH=6, two enqueue and two dequeue lanes.
module tb_multi_lane_fifo;

    localparam int DEPTH = 6;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004;
    localparam logic [31:0] E = 32'hEEEE_0005;
    localparam logic [31:0] F = 32'hFFFF_0006;
    localparam logic [31:0] G = 32'h6666_0007;
    localparam logic [31:0] H = 32'h8888_0008;
    localparam logic [31:0] JUNK0 = 32'hDEAD_0000;
    localparam logic [31:0] JUNK1 = 32'hDEAD_0001;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        flush_i;
    logic [IN_W-1:0]             enq_valid_i;
    logic [IN_W-1:0][31:0]       enq_data_i;
    logic                        enq_ready_o;
    logic [OUT_W-1:0]            deq_valid_o;
    logic [OUT_W-1:0][31:0]      deq_data_o;
    logic [OUT_W-1:0]            deq_ready_i;
    logic [CNT_W-1:0]            count_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q [$];

    always #5 clk = ~clk;

    multi_lane_fifo #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .T     (logic [31:0]),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_data_i  (enq_data_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_data_o  (deq_data_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t cnt=%0d rdy=%b dv=%b d0=%h d1=%h", $time, count_o, enq_ready_o,
                 deq_valid_o, deq_data_o[0], deq_data_o[1]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; enq_valid_i = '0; enq_data_i = '0; deq_ready_i = '0;
        repeat (3) tick();
        n_checks++; if (enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", enq_ready_o); end
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++; if (deq_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", deq_valid_o); end
        rst_n = 1'b1;
        #2;
        n_checks++; if (enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL release_ready_before_edge: got %b expected 0", enq_ready_o); end
        tick();
        n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready_after_edge: got %b expected 1", enq_ready_o); end
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL release_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_compaction();
        enq_valid_i = 2'b10; enq_data_i = {B, A};
        tick();
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL compact_count1: got %0d expected 1", count_o); end
        n_checks++; if (deq_valid_o !== 2'b01) begin n_fail++; $display("FAIL compact_valid1: got %b expected 01", deq_valid_o); end
        n_checks++; if (deq_data_o[0] !== B) begin n_fail++; $display("FAIL compact_lane0_first: got %h expected %h", deq_data_o[0], B); end
        enq_valid_i = 2'b11; enq_data_i = {D, C};
        tick();
        enq_valid_i = 2'b00;
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL compact_count3: got %0d expected 3", count_o); end
        n_checks++; if (deq_valid_o !== 2'b11) begin n_fail++; $display("FAIL compact_valid3: got %b expected 11", deq_valid_o); end
        n_checks++; if (deq_data_o[0] !== B) begin n_fail++; $display("FAIL compact_lane0: got %h expected %h", deq_data_o[0], B); end
        n_checks++; if (deq_data_o[1] !== C) begin n_fail++; $display("FAIL compact_lane1: got %h expected %h", deq_data_o[1], C); end
    endtask

    task automatic test_prefix_pop();
        deq_ready_i = 2'b10;
        tick();
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL prefix_blocked_count: got %0d expected 3", count_o); end
        n_checks++; if (deq_data_o[0] !== B) begin n_fail++; $display("FAIL prefix_blocked_data: got %h expected %h", deq_data_o[0], B); end
        deq_ready_i = 2'b01;
        tick();
        deq_ready_i = 2'b00;
        n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL prefix_one_count: got %0d expected 2", count_o); end
        n_checks++; if (deq_data_o[0] !== C) begin n_fail++; $display("FAIL prefix_one_lane0: got %h expected %h", deq_data_o[0], C); end
        n_checks++; if (deq_data_o[1] !== D) begin n_fail++; $display("FAIL prefix_one_lane1: got %h expected %h", deq_data_o[1], D); end
    endtask

    task automatic test_full_wrap();
        enq_valid_i = 2'b11; enq_data_i = {F, E};
        tick();
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count4: got %0d expected 4", count_o); end
        n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready4: got %b expected 1", enq_ready_o); end
        enq_valid_i = 2'b01; enq_data_i = {JUNK0, G};
        tick();
        n_checks++; if (count_o !== 3'd5) begin n_fail++; $display("FAIL fill_count5: got %0d expected 5", count_o); end
        n_checks++; if (enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready5: got %b expected 0", enq_ready_o); end
        enq_valid_i = 2'b11; enq_data_i = {JUNK1, JUNK0};
        tick();
        n_checks++; if (count_o !== 3'd5) begin n_fail++; $display("FAIL ignored_enq_count: got %0d expected 5", count_o); end
        n_checks++; if (enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL ignored_enq_ready: got %b expected 0", enq_ready_o); end
        enq_valid_i = 2'b00; deq_ready_i = 2'b11;
        tick();
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL drain_count: got %0d expected 3", count_o); end
        n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b expected 1", enq_ready_o); end
        q.delete();
        q.push_back(E); q.push_back(F); q.push_back(G);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] v0, v1;
            v0 = 32'h0000_0100 + 32'(2 * i);
            v1 = v0 + 32'd1;
            n_checks++; if (deq_data_o[0] !== q[0]) begin n_fail++; $display("FAIL wrap_lane0[%0d]: got %h expected %h", i, deq_data_o[0], q[0]); end
            n_checks++; if (deq_data_o[1] !== q[1]) begin n_fail++; $display("FAIL wrap_lane1[%0d]: got %h expected %h", i, deq_data_o[1], q[1]); end
            enq_valid_i = 2'b11; enq_data_i = {v1, v0}; deq_ready_i = 2'b11;
            tick();
            void'(q.pop_front());
            void'(q.pop_front());
            q.push_back(v0);
            q.push_back(v1);
            n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 3", i, count_o); end
        end
        enq_valid_i = 2'b00; deq_ready_i = 2'b00;
        n_checks++; if (deq_data_o[0] !== q[0]) begin n_fail++; $display("FAIL wrap_final_lane0: got %h expected %h", deq_data_o[0], q[0]); end
        n_checks++; if (deq_data_o[1] !== q[1]) begin n_fail++; $display("FAIL wrap_final_lane1: got %h expected %h", deq_data_o[1], q[1]); end
    endtask

    task automatic test_flush();
        enq_valid_i = 2'b10; enq_data_i = {H, JUNK0};
        tick();
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 4", count_o); end
        flush_i = 1'b1; enq_valid_i = 2'b11; enq_data_i = {JUNK1, JUNK0}; deq_ready_i = 2'b11;
        tick();
        flush_i = 1'b0; enq_valid_i = 2'b00; deq_ready_i = 2'b00;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        n_checks++; if (deq_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b expected 00", deq_valid_o); end
        n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", enq_ready_o); end
        tick();
        n_checks++; if (deq_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_idle_valid: got %b expected 00", deq_valid_o); end
        enq_valid_i = 2'b11; enq_data_i = {32'h5555_0002, 32'h5555_0001};
        tick();
        enq_valid_i = 2'b00;
        n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL post_flush_count: got %0d expected 2", count_o); end
        n_checks++; if (deq_data_o[0] !== 32'h5555_0001) begin n_fail++; $display("FAIL post_flush_lane0: got %h expected 55550001", deq_data_o[0]); end
        n_checks++; if (deq_data_o[1] !== 32'h5555_0002) begin n_fail++; $display("FAIL post_flush_lane1: got %h expected 55550002", deq_data_o[1]); end
    endtask

    task automatic test_reset_mid_op();
        enq_valid_i = 2'b11; enq_data_i = {32'h5555_0004, 32'h5555_0003};
        tick();
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL midrst_pre_count: got %0d expected 4", count_o); end
        rst_n = 1'b0; flush_i = 1'b1; enq_data_i = {JUNK1, JUNK0}; deq_ready_i = 2'b11;
        tick();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count_o); end
        n_checks++; if (enq_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", enq_ready_o); end
        n_checks++; if (deq_valid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_valid: got %b expected 00", deq_valid_o); end
        rst_n = 1'b1; flush_i = 1'b0; enq_valid_i = 2'b00; deq_ready_i = 2'b00;
        tick();
        n_checks++; if (enq_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready: got %b expected 1", enq_ready_o); end
        enq_valid_i = 2'b01; enq_data_i = {JUNK0, 32'h7777_0001};
        tick();
        enq_valid_i = 2'b00;
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL midrst_fresh_count: got %0d expected 1", count_o); end
        n_checks++; if (deq_valid_o !== 2'b01) begin n_fail++; $display("FAIL midrst_fresh_valid: got %b expected 01", deq_valid_o); end
        n_checks++; if (deq_data_o[0] !== 32'h7777_0001) begin n_fail++; $display("FAIL midrst_fresh_data: got %h expected 77770001", deq_data_o[0]); end
    endtask

    initial begin
        test_reset();
        test_compaction();
        test_prefix_pop();
        test_full_wrap();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
